// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one masked write port, two registered read ports
// and the flat export of the low registers.
interface reg_file_2r1w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_EXPORT = 4
);
    logic                           WrEn;
    logic [ADDR_WIDTH-1:0]          WrAddr;
    logic [DATA_WIDTH-1:0]          WrData;
    logic [DATA_WIDTH-1:0]          WrBitEn;
    logic                           WrErr;

    logic                           RdEnA;
    logic [ADDR_WIDTH-1:0]          RdAddrA;
    logic [DATA_WIDTH-1:0]          RdDataA;
    logic                           RdValidA;

    logic                           RdEnB;
    logic [ADDR_WIDTH-1:0]          RdAddrB;
    logic [DATA_WIDTH-1:0]          RdDataB;
    logic                           RdValidB;

    logic [NUM_EXPORT*DATA_WIDTH-1:0] Reg_out;

    modport master (
        output WrEn, WrAddr, WrData, WrBitEn,
        output RdEnA, RdAddrA, RdEnB, RdAddrB,
        input  WrErr, RdDataA, RdValidA, RdDataB, RdValidB, Reg_out
    );

    modport slave (
        input  WrEn, WrAddr, WrData, WrBitEn,
        input  RdEnA, RdAddrA, RdEnB, RdAddrB,
        output WrErr, RdDataA, RdValidA, RdDataB, RdValidB, Reg_out
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: masked write port with write-protect, two latency-1
// read ports with optional read-during-write bypass, low registers exported flat.
module reg_file_2r1w #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_FILE_DEPTH = 16,
    parameter int ADDR_WIDTH     = $clog2(REG_FILE_DEPTH),
    parameter int NUM_EXPORT     = 4,
    parameter logic [REG_FILE_DEPTH*DATA_WIDTH-1:0] RESET_VALUES =
        ((REG_FILE_DEPTH*DATA_WIDTH)'(8'h20) << (3*DATA_WIDTH)) |
        ((REG_FILE_DEPTH*DATA_WIDTH)'(8'h81) << (2*DATA_WIDTH)),
    parameter logic [REG_FILE_DEPTH-1:0] RO_MASK = '0,
    parameter bit WR_BYPASS = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    reg_file_2r1w_if.slave  bus
);
    // Masks padded to the full address span so any address can index them safely;
    // bits beyond the depth read as "not present" / "not protected".
    localparam int ADDR_SPAN = 1 << ADDR_WIDTH;
    localparam logic [ADDR_SPAN-1:0] PRESENT_MASK = ADDR_SPAN'({REG_FILE_DEPTH{1'b1}});
    localparam logic [ADDR_SPAN-1:0] RO_MASK_EXT  = ADDR_SPAN'(RO_MASK);

    logic [DATA_WIDTH-1:0] regs_reg [REG_FILE_DEPTH];
    logic                  wr_err_reg;
    logic                  wr_accept;
    logic                  wr_reject;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;

    logic                  rd_en   [2];
    logic [ADDR_WIDTH-1:0] rd_addr [2];

    assign wr_accept = bus.WrEn && PRESENT_MASK[bus.WrAddr] && !RO_MASK_EXT[bus.WrAddr];
    assign wr_reject = bus.WrEn && !wr_accept;

    always_comb begin
        wr_old = '0;
        if (PRESENT_MASK[bus.WrAddr]) begin
            wr_old = regs_reg[bus.WrAddr];
        end
    end

    assign wr_merged = (wr_old & ~bus.WrBitEn) | (bus.WrData & bus.WrBitEn);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_FILE_DEPTH; i++) begin
                regs_reg[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
            wr_err_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                regs_reg[bus.WrAddr] <= wr_merged;
            end
            wr_err_reg <= wr_reject;
        end
    end

    assign bus.WrErr = wr_err_reg;

    assign rd_en[0]   = bus.RdEnA;
    assign rd_addr[0] = bus.RdAddrA;
    assign rd_en[1]   = bus.RdEnB;
    assign rd_addr[1] = bus.RdAddrB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] rd_next;
            logic [DATA_WIDTH-1:0] rd_data_reg;
            logic                  rd_valid_reg;

            // Rejected writes never win the bypass because wr_accept gates it.
            always_comb begin
                rd_next = '0;
                if (PRESENT_MASK[rd_addr[gi]]) begin
                    if (WR_BYPASS && wr_accept && (rd_addr[gi] == bus.WrAddr)) begin
                        rd_next = wr_merged;
                    end else begin
                        rd_next = regs_reg[rd_addr[gi]];
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        rd_data_reg <= rd_next;
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_EXPORT; gi++) begin : g_export
            assign bus.Reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign bus.RdDataA  = g_rd[0].rd_data_reg;
    assign bus.RdValidA = g_rd[0].rd_valid_reg;
    assign bus.RdDataB  = g_rd[1].rd_data_reg;
    assign bus.RdValidB = g_rd[1].rd_valid_reg;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances (depth 16/bypass on, depth 12/bypass off)
// share one stimulus stream and are checked against an array-based model.
module tb_reg_file_2r1w;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NE = 4;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] wbe;
        logic          rae;
        logic [AW-1:0] raa;
        logic          rbe;
        logic [AW-1:0] rba;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic [DW-1:0] exp_rd;
        logic          exp_v;
        logic          exp_err;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_EXPORT(NE)) bus_a ();
    reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_EXPORT(NE)) bus_b ();

    reg_file_2r1w #(
        .DATA_WIDTH(DW), .REG_FILE_DEPTH(16), .NUM_EXPORT(NE),
        .RO_MASK(16'h0004), .WR_BYPASS(1'b1)
    ) u_dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));

    reg_file_2r1w #(
        .DATA_WIDTH(DW), .REG_FILE_DEPTH(12), .NUM_EXPORT(NE),
        .RO_MASK(12'h010), .WR_BYPASS(1'b0)
    ) u_dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

    // Reference model: plain register arrays plus the last values each read port returned.
    int            depth  [2] = '{16, 12};
    logic [15:0]   ro     [2] = '{16'h0004, 16'h0010};
    bit            bypass [2] = '{1'b1, 1'b0};
    logic [DW-1:0] mem    [2][16];
    logic [DW-1:0] m_rd   [2][2];
    logic          m_v    [2][2];
    logic          m_err  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic we, input int wa, input int wd,
                                 input int wbe, input logic rae, input int raa,
                                 input logic rbe, input int rba);
        stim_t s;
        s.rst = rst; s.we = we; s.wa = AW'(wa); s.wd = DW'(wd); s.wbe = DW'(wbe);
        s.rae = rae; s.raa = AW'(raa); s.rbe = rbe; s.rba = AW'(rba);
        return s;
    endfunction

    function automatic vec_t tv(input logic rst, input logic we, input int wa, input int wd,
                                input int wbe, input logic re, input int ra,
                                input int exp_rd, input logic exp_v, input logic exp_err);
        vec_t v;
        v.s = mk(rst, we, wa, wd, wbe, re, ra, re, ra);
        v.exp_rd = DW'(exp_rd); v.exp_v = exp_v; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic model_step(input stim_t s);
        logic          wr_ok;
        logic [DW-1:0] merged;
        logic          en   [2];
        logic [AW-1:0] addr [2];
        en[0] = s.rae; addr[0] = s.raa; en[1] = s.rbe; addr[1] = s.rba;
        for (int d = 0; d < 2; d++) begin
            if (s.rst) begin
                for (int r = 0; r < 16; r++) mem[d][r] = 8'h00;
                mem[d][2] = 8'h81;
                mem[d][3] = 8'h20;
                for (int p = 0; p < 2; p++) begin m_rd[d][p] = 8'h00; m_v[d][p] = 1'b0; end
                m_err[d] = 1'b0;
            end else begin
                wr_ok  = s.we && (int'(s.wa) < depth[d]) && !ro[d][s.wa];
                merged = (mem[d][s.wa] & ~s.wbe) | (s.wd & s.wbe);
                m_err[d] = s.we && !wr_ok;
                for (int p = 0; p < 2; p++) begin
                    m_v[d][p] = en[p];
                    if (en[p]) begin
                        if (int'(addr[p]) >= depth[d])                       m_rd[d][p] = 8'h00;
                        else if (wr_ok && bypass[d] && addr[p] == s.wa)      m_rd[d][p] = merged;
                        else                                                 m_rd[d][p] = mem[d][addr[p]];
                    end
                end
                if (wr_ok) mem[d][s.wa] = merged;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [DW-1:0] rda, input logic va,
                             input logic [DW-1:0] rdb, input logic vb, input logic err,
                             input logic [NE*DW-1:0] rout);
        chk($sformatf("dut%0d_rdA", d),   32'(rda), 32'(m_rd[d][0]));
        chk($sformatf("dut%0d_vA", d),    32'(va),  32'(m_v[d][0]));
        chk($sformatf("dut%0d_rdB", d),   32'(rdb), 32'(m_rd[d][1]));
        chk($sformatf("dut%0d_vB", d),    32'(vb),  32'(m_v[d][1]));
        chk($sformatf("dut%0d_err", d),   32'(err), 32'(m_err[d]));
        chk($sformatf("dut%0d_regout", d), 32'(rout),
            {mem[d][3], mem[d][2], mem[d][1], mem[d][0]});
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic apply(input stim_t s);
        RST = s.rst;
        bus_a.WrEn = s.we;   bus_a.WrAddr = s.wa;   bus_a.WrData = s.wd;  bus_a.WrBitEn = s.wbe;
        bus_a.RdEnA = s.rae; bus_a.RdAddrA = s.raa; bus_a.RdEnB = s.rbe;  bus_a.RdAddrB = s.rba;
        bus_b.WrEn = s.we;   bus_b.WrAddr = s.wa;   bus_b.WrData = s.wd;  bus_b.WrBitEn = s.wbe;
        bus_b.RdEnA = s.rae; bus_b.RdAddrA = s.raa; bus_b.RdEnB = s.rbe;  bus_b.RdAddrB = s.rba;
        model_step(s);
        @(negedge CLK);
        $display("t=%0t rst=%0b wr=%0b@%0d d=%h be=%h rdA=%0b@%0d rdB=%0b@%0d | a:%h/%0b b:%h/%0b",
                 $time, s.rst, s.we, s.wa, s.wd, s.wbe, s.rae, s.raa, s.rbe, s.rba,
                 bus_a.RdDataA, bus_a.RdValidA, bus_b.RdDataA, bus_b.RdValidA);
        check_dut(0, bus_a.RdDataA, bus_a.RdValidA, bus_a.RdDataB, bus_a.RdValidB,
                  bus_a.WrErr, bus_a.Reg_out);
        check_dut(1, bus_b.RdDataA, bus_b.RdValidA, bus_b.RdDataB, bus_b.RdValidB,
                  bus_b.WrErr, bus_b.Reg_out);
    endtask

    initial begin
        vec_t vecs [15];
        //            rst we  wa  wd     wbe    re  ra  exp_rd v  err   (instance A)
        vecs[0]  = tv(1, 0,  0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 0);
        vecs[1]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  0, 8'h00, 1, 0);
        vecs[2]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  1, 8'h00, 1, 0);
        vecs[3]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  2, 8'h81, 1, 0);
        vecs[4]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  3, 8'h20, 1, 0);
        vecs[5]  = tv(0, 1,  5, 8'hAA, 8'hFF, 0,  0, 8'h20, 0, 0);
        vecs[6]  = tv(0, 1,  5, 8'h55, 8'h0F, 0,  0, 8'h20, 0, 0);
        vecs[7]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  5, 8'hA5, 1, 0);
        vecs[8]  = tv(0, 1,  2, 8'hFF, 8'hFF, 0,  0, 8'hA5, 0, 1);
        vecs[9]  = tv(0, 0,  0, 8'h00, 8'h00, 1,  2, 8'h81, 1, 0);
        vecs[10] = tv(0, 1,  7, 8'h3C, 8'hFF, 1,  7, 8'h3C, 1, 0);
        vecs[11] = tv(0, 1,  9, 8'h77, 8'hFF, 0,  0, 8'h3C, 0, 0);
        vecs[12] = tv(1, 0,  0, 8'h00, 8'h00, 1,  9, 8'h00, 0, 0);
        vecs[13] = tv(0, 0,  0, 8'h00, 8'h00, 1,  9, 8'h00, 1, 0);
        vecs[14] = tv(0, 1,  4, 8'hFF, 8'h00, 1,  4, 8'h00, 1, 0);

        RST = 1'b1;
        bus_a.WrEn = 0; bus_a.WrAddr = 0; bus_a.WrData = 0; bus_a.WrBitEn = 0;
        bus_a.RdEnA = 0; bus_a.RdAddrA = 0; bus_a.RdEnB = 0; bus_a.RdAddrB = 0;
        bus_b.WrEn = 0; bus_b.WrAddr = 0; bus_b.WrData = 0; bus_b.WrBitEn = 0;
        bus_b.RdEnA = 0; bus_b.RdAddrA = 0; bus_b.RdEnB = 0; bus_b.RdAddrB = 0;
        @(negedge CLK);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].s);
            chk($sformatf("vec%0d_rdA", i), 32'(bus_a.RdDataA),  32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_rdB", i), 32'(bus_a.RdDataB),  32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_vA", i),  32'(bus_a.RdValidA), 32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_err", i), 32'(bus_a.WrErr),    32'(vecs[i].exp_err));
            if (i == 4 || i == 8) chk($sformatf("vec%0d_regout", i), bus_a.Reg_out, 32'h2081_0000);
            if (i == 10) chk("vec10_nobypass_b", 32'(bus_b.RdDataA), 32'h00);
        end

        // Depth-12 instance: out-of-range write and read, bypass disabled.
        apply(mk(0, 1, 13, 8'h5A, 8'hFF, 0, 0, 0, 0));
        chk("b_oor_wr_err", 32'(bus_b.WrErr), 32'h1);
        apply(mk(0, 1, 8, 8'h5A, 8'hFF, 1, 8, 1, 8));
        chk("b_err_one_cycle", 32'(bus_b.WrErr), 32'h0);
        chk("b_rdw_old_a", 32'(bus_b.RdDataA), 32'h00);
        chk("b_rdw_old_b", 32'(bus_b.RdDataB), 32'h00);
        chk("a_rdw_new", 32'(bus_a.RdDataA), 32'h5A);
        apply(mk(0, 0, 0, 0, 0, 1, 8, 0, 0));
        chk("b_rd8_after", 32'(bus_b.RdDataA), 32'h5A);
        apply(mk(0, 0, 0, 0, 0, 1, 14, 1, 14));
        chk("b_oor_rd_data", 32'(bus_b.RdDataA), 32'h00);
        chk("b_oor_rd_valid", 32'(bus_b.RdValidA), 32'h1);

        for (int n = 0; n < 500; n++) begin
            apply(mk(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15))));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the system register file.
- Provides one masked write port and two independent registered read ports, with per-register reset values and a per-register write-protect mask.
- Reads and writes may occur in the same cycle, with a selectable read-during-write bypass.
- Exports the first NUM_EXPORT registers as a flat bus for the config consumers (UART/ALU/clock-divider settings).

Parameters:
- DATA_WIDTH, 8, bits per register.
- REG_FILE_DEPTH, 16, number of registers; need not be a power of two.
- ADDR_WIDTH, $clog2(REG_FILE_DEPTH), address width.
- NUM_EXPORT, 4, registers exported on Reg_out; must be 1..REG_FILE_DEPTH.
- RESET_VALUES, {REG_FILE_DEPTH*DATA_WIDTH} vector, default 0 except reg2=8'h81 and reg3=8'h20. Register i reset value = RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH].
- RO_MASK, REG_FILE_DEPTH bits, default 0; bit i=1 makes register i write-protected.
- WR_BYPASS, 1; 1 = a read of the address being written returns the new value, 0 = it returns the old value.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  DATA_WIDTH  write data.
- WrBitEn  in  DATA_WIDTH  per-bit write enable.
- WrErr  out  1  one-cycle pulse: write rejected.
- RdEnA  in  1  read request, port A.
- RdAddrA  in  ADDR_WIDTH  read address A.
- RdDataA  out  DATA_WIDTH  read data A (registered).
- RdValidA  out  1  one-cycle pulse, RdDataA updated.
- RdEnB, RdAddrB, RdDataB, RdValidB: identical to port A, for port B.
- Reg_out  out  NUM_EXPORT*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (RST=1 at a rising edge):
  - All registers load RESET_VALUES.
  - RdDataA/B = 0; RdValidA/B = 0; WrErr = 0.
  - Reset overrides any simultaneous read or write; an in-flight read produces no valid pulse.
- Write:
  - Accepted when WrEn=1, WrAddr < REG_FILE_DEPTH and RO_MASK[WrAddr]=0.
  - Next state: reg = (reg & ~WrBitEn) | (WrData & WrBitEn).
  - WrBitEn = 0 with an accepted write leaves the register unchanged and raises no error.
- Write rejection:
  - Condition: WrEn=1 and (WrAddr >= REG_FILE_DEPTH or RO_MASK[WrAddr]=1).
  - Register array unchanged; WrErr=1 for exactly the next cycle.
  - Otherwise WrErr=0.
- Read (each port independent, latency 1):
  - When RdEnX=1 at edge N, RdDataX holds the value after edge N and RdValidX=1 for that cycle only.
  - When RdEnX=0, RdDataX holds its last value and RdValidX=0.
  - Back-to-back reads every cycle are allowed; valid stays high.
- Out-of-range read (RdAddrX >= REG_FILE_DEPTH): RdDataX=0, RdValidX=1.
- Read-during-write (same address, same edge, write accepted):
  - WR_BYPASS=1: the returned value is the post-merge value.
  - WR_BYPASS=0: the returned value is the pre-write value.
  - A rejected write never affects read data.
- Both ports may read the same address in the same cycle; both return identical data.
- Reg_out:
  - Driven directly from register storage, with no extra latency beyond the write edge.
  - Write-protected registers still appear on Reg_out.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read addresses 0..3 on port A → 00, 00, 81, 20; RdValidA high one cycle each. Reg_out = 32'h2081_0000 (reg3..reg0).
- WrEn, WrAddr=5, WrData=AA, WrBitEn=FF; next cycle WrData=55, WrBitEn=0F → read 5 returns A5; WrErr stays 0.
- RO_MASK bit 2 set; write FF to address 2 → WrErr pulses one cycle; reg2 stays 81; Reg_out unchanged.
- Same-edge write 3C to address 7 plus RdEnA and RdEnB at address 7 (prior value 00) → both ports return 3C with WR_BYPASS=1, and 00 with WR_BYPASS=0.
- REG_FILE_DEPTH=12: write to 13 → WrErr pulse, no change; read 14 → RdData=0, RdValid=1.
- Reset asserted for one cycle between write and read of address 9 (value 77) → read returns reset value 00; no RdValid in the reset cycle.
